// File: rtl/supply_sequencer.sv
// supply_sequencer: power-up supervisor for the +5 V regulator and load switch.
// Synchronises the regulator's input-present and output-good comparators,
// sequences the regulator enable and the board reset, and latches a fault
// code on ramp timeout, instability during settling, or brown-out.
// Optional feature macro: SUPPLY_SEQ_RETRY_EN (automatic retry after a
// cooldown period; undefined by default, in which case every fault latches
// until clr_fault).
module supply_sequencer #(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int SETTLE_CYC   = 5000,
  parameter int TIMEOUT_CYC  = 20000,
  parameter int COOLDOWN_CYC = 50000,
  parameter int RETRY_MAX    = 3,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       vin_ok,
  input  logic       vout_ok,
  input  logic       clr_fault,
  output logic       reg_en,
  output logic       sys_rst_n,
  output logic       pgood,
  output logic       fault,
  output logic [1:0] fault_code
);

  // Every cycle count shares one CNT_W-bit counter, so each must fit in it.
  if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC >= (1 << CNT_W) ||
      SETTLE_CYC   < 1 || SETTLE_CYC   >= (1 << CNT_W) ||
      TIMEOUT_CYC  < 1 || TIMEOUT_CYC  >= (1 << CNT_W) ||
      COOLDOWN_CYC < 1 || COOLDOWN_CYC >= (1 << CNT_W) ||
      RETRY_MAX    < 0) begin : g_param_check
    $error("supply_sequencer: cycle parameters must lie in 1 .. 2**CNT_W-1");
  end

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_RAMP   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_ON     = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b01;
  localparam logic [1:0] CODE_UNSTABLE = 2'b10;
  localparam logic [1:0] CODE_BROWNOUT = 2'b11;

  // A phase ends on the edge that sees its N-th qualifying cycle, i.e. while
  // the counter still holds N-1 (the counter restarts at 0 on state entry).
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic             vin_meta;
  logic             vin_s;
  logic             vout_meta;
  logic             vout_s;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             fault_nxt;
  logic [1:0]       code_nxt;
  logic             rail_lost;

`ifdef SUPPLY_SEQ_RETRY_EN
  localparam int RTY_W = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_LIM   = RTY_W'(RETRY_MAX);

  logic [RTY_W-1:0] retry_cnt;
  logic [RTY_W-1:0] retry_nxt;
`endif

  // Two-flop synchronisers for the asynchronous comparator inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vin_meta  <= 1'b0;
      vin_s     <= 1'b0;
      vout_meta <= 1'b0;
      vout_s    <= 1'b0;
    end else begin
      vin_meta  <= vin_ok;
      vin_s     <= vin_meta;
      vout_meta <= vout_ok;
      vout_s    <= vout_meta;
    end
  end

  // Next-state, counter and fault-register logic for the sequencer.
  always_comb begin
    cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    state_nxt = state;
    cnt_nxt   = cnt_inc;
    fault_nxt = fault;
    code_nxt  = fault_code;
`ifdef SUPPLY_SEQ_RETRY_EN
    retry_nxt = retry_cnt;
`endif
    // Losing the input supply or software enable is a clean shutdown and
    // wins over any fault seen on the same cycle.
    rail_lost = !vin_s || !enable;

    case (state)
      ST_OFF: begin
        if (vin_s && enable) begin
          if (cnt == DEB_LAST) begin
            state_nxt = ST_RAMP;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = '0;
        end
      end

      ST_RAMP: begin
        if (rail_lost) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end else if (vout_s) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end else if (cnt == TMO_LAST) begin
          state_nxt = ST_FAULT;
          cnt_nxt   = '0;
          fault_nxt = 1'b1;
          code_nxt  = CODE_TIMEOUT;
        end
      end

      ST_SETTLE: begin
        if (rail_lost) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end else if (!vout_s) begin
          state_nxt = ST_FAULT;
          cnt_nxt   = '0;
          fault_nxt = 1'b1;
          code_nxt  = CODE_UNSTABLE;
        end else if (cnt == SET_LAST) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
`ifdef SUPPLY_SEQ_RETRY_EN
          // A successful power-up forgives earlier retried faults.
          retry_nxt = '0;
          fault_nxt = 1'b0;
          code_nxt  = CODE_NONE;
`endif
        end
      end

      ST_ON: begin
        if (rail_lost) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end else if (!vout_s) begin
          state_nxt = ST_FAULT;
          cnt_nxt   = '0;
          fault_nxt = 1'b1;
          code_nxt  = CODE_BROWNOUT;
        end
      end

      ST_FAULT: begin
        // enable and vin_s are deliberately ignored here.
        if (clr_fault) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
          fault_nxt = 1'b0;
          code_nxt  = CODE_NONE;
`ifdef SUPPLY_SEQ_RETRY_EN
          retry_nxt = '0;
        end else if (retry_cnt < RTY_LIM && cnt == COOL_LAST) begin
          // Cooldown over: try again, keeping the fault flag and code visible.
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
          retry_nxt = retry_cnt + 1'b1;
`endif
        end
      end

      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs, all decoded from the next state
  // so the outputs move on the same edge as the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      cnt        <= '0;
      reg_en     <= 1'b0;
      sys_rst_n  <= 1'b0;
      pgood      <= 1'b0;
      fault      <= 1'b0;
      fault_code <= CODE_NONE;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      reg_en     <= (state_nxt == ST_RAMP) || (state_nxt == ST_SETTLE) ||
                    (state_nxt == ST_ON);
      // Reset release and power-good only in ON, where reg_en is also high.
      sys_rst_n  <= (state_nxt == ST_ON);
      pgood      <= (state_nxt == ST_ON);
      fault      <= fault_nxt;
      fault_code <= code_nxt;
    end
  end

`ifdef SUPPLY_SEQ_RETRY_EN
  // Retry counter: number of automatic restarts since the last clean power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else begin
      retry_cnt <= retry_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_supply_sequencer.sv
// tb_supply_sequencer: directed bench for supply_sequencer with shortened
// cycle parameters. Output vector order: {reg_en, sys_rst_n, pgood, fault,
// fault_code[1:0]}. Retry steps are built only with SUPPLY_SEQ_RETRY_EN.
module tb_supply_sequencer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       vin_ok;
  logic       vout_ok;
  logic       clr_fault;
  logic       reg_en;
  logic       sys_rst_n;
  logic       pgood;
  logic       fault;
  logic [1:0] fault_code;
  logic [5:0] outs;

  int total;
  int bad;

  localparam logic [5:0] O_OFF    = 6'b000000;
  localparam logic [5:0] O_RAMP   = 6'b100000;
  localparam logic [5:0] O_ON     = 6'b111000;
  localparam logic [5:0] O_F_TMO  = 6'b000101;
  localparam logic [5:0] O_F_UNST = 6'b000110;
  localparam logic [5:0] O_F_BO   = 6'b000111;

  supply_sequencer #(
    .DEBOUNCE_CYC(4),
    .SETTLE_CYC  (8),
    .TIMEOUT_CYC (16),
    .COOLDOWN_CYC(10),
    .RETRY_MAX   (2),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .vin_ok    (vin_ok),
    .vout_ok   (vout_ok),
    .clr_fault (clr_fault),
    .reg_en    (reg_en),
    .sys_rst_n (sys_rst_n),
    .pgood     (pgood),
    .fault     (fault),
    .fault_code(fault_code)
  );

  assign outs = {reg_en, sys_rst_n, pgood, fault, fault_code};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n active edges; returns on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    enable    = 1'b0;
    vin_ok    = 1'b0;
    vout_ok   = 1'b0;
    clr_fault = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1 check("reset", outs, O_OFF);

    // Normal power-up: vin rises before edge 1, reg_en after edge 6.
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    cyc(2);
    vin_ok = 1'b1;
    cyc(5);  check("deb_pre", outs, O_OFF);
    cyc(1);  check("ramp_entry", outs, O_RAMP);
    cyc(3);  vout_ok = 1'b1;
    cyc(10); check("settle_pre", outs, O_RAMP);
    cyc(1);  check("power_on", outs, O_ON);

    // Brown-out: vout falls, fault 11 three edges later.
    vout_ok = 1'b0;
    cyc(2);  check("bo_pre", outs, O_ON);
    cyc(1);  check("bo_fault", outs, O_F_BO);
    clr_fault = 1'b1;
    cyc(1);  clr_fault = 1'b0;
    check("bo_clear", outs, O_OFF);
    cyc(3);  check("redeb_pre", outs, O_OFF);
    cyc(1);  check("redeb_ramp", outs, O_RAMP);

    // Ramp timeout: 16 cycles in RAMP with vout low.
    cyc(15); check("tmo_pre", outs, O_RAMP);
    cyc(1);  check("tmo_fault", outs, O_F_TMO);
    enable = 1'b0;
    cyc(3);  check("fault_hold", outs, O_F_TMO);
    enable = 1'b1;
    clr_fault = 1'b1;
    cyc(1);  clr_fault = 1'b0;
    check("tmo_clear", outs, O_OFF);
    vin_ok = 1'b0;
    cyc(4);  check("vin_low", outs, O_OFF);

    // Debounce glitch: high 3, low 1, then high.
    vin_ok = 1'b1;
    cyc(3);  vin_ok = 1'b0;
    cyc(1);  vin_ok = 1'b1;
    cyc(2);  check("glitch_mid", outs, O_OFF);
    cyc(3);  check("glitch_pre", outs, O_OFF);
    cyc(1);  check("glitch_ramp", outs, O_RAMP);
    vout_ok = 1'b1;
    cyc(10); check("settle_pre2", outs, O_RAMP);
    cyc(1);  check("power_on2", outs, O_ON);
    clr_fault = 1'b1;
    cyc(1);  clr_fault = 1'b0;
    check("clr_noeffect", outs, O_ON);

    // vin and vout fall together: clean shutdown wins over brown-out.
    vin_ok  = 1'b0;
    vout_ok = 1'b0;
    cyc(2);  check("both_pre", outs, O_ON);
    cyc(1);  check("both_fall", outs, O_OFF);

    // Instability during settle: fault code 10.
    vin_ok = 1'b1;
    cyc(5);  check("ramp3_pre", outs, O_OFF);
    cyc(1);  check("ramp3", outs, O_RAMP);
    vout_ok = 1'b1;
    cyc(5);  vout_ok = 1'b0;
    cyc(2);  check("unst_pre", outs, O_RAMP);
    cyc(1);  check("unst_fault", outs, O_F_UNST);
    clr_fault = 1'b1;
    cyc(1);  clr_fault = 1'b0;
    check("unst_clear", outs, O_OFF);

`ifdef SUPPLY_SEQ_RETRY_EN
    // Permanent vout low: two retries 10 cycles apart, then latched 01.
    cyc(19); check("r_ramp1", outs, O_RAMP);
    cyc(1);  check("r_fault1", outs, O_F_TMO);
    cyc(13); check("r_off1", outs, O_F_TMO);
    cyc(1);  check("r_ramp2", outs, O_RAMP | O_F_TMO);
    cyc(15); check("r_ramp2_end", outs, O_RAMP | O_F_TMO);
    cyc(1);  check("r_fault2", outs, O_F_TMO);
    cyc(13); check("r_off2", outs, O_F_TMO);
    cyc(1);  check("r_ramp3", outs, O_RAMP | O_F_TMO);
    cyc(16); check("r_fault3", outs, O_F_TMO);
    cyc(14); check("r_latched", outs, O_F_TMO);
    cyc(6);  check("r_latched2", outs, O_F_TMO);
    clr_fault = 1'b1;
    cyc(1);  clr_fault = 1'b0;
    check("r_clear", outs, O_OFF);
`endif

    // Asynchronous reset in the middle of RAMP.
    cyc(6);  check("pre_rst", outs, O_RAMP);
    #2 rst_n = 1'b0;
    #1 check("async_rst", outs, O_OFF);
    cyc(2);  check("rst_hold", outs, O_OFF);
    rst_n = 1'b1;
    cyc(5);  check("post_rst_pre", outs, O_OFF);
    cyc(1);  check("post_rst_ramp", outs, O_RAMP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
